// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - operation codes and FSM states for the iterative multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_divstep.sv
// rtl/muldiv_divstep.sv - one restoring-division step on unsigned magnitudes
module muldiv_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH+1:0] shifted;
    logic             fits;

    // The dividend bits live in quot_in and are pulled out MSB-first as quotient bits enter at the LSB.
    always_comb begin
        shifted  = {rem_in, quot_in[WIDTH-1]};
        fits     = shifted >= {2'b00, divisor};
        rem_out  = (WIDTH + 1)'(fits ? shifted - {2'b00, divisor} : shifted);
        quot_out = {quot_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - WIDTH-cycle sequential MULT/DIV engine owning the HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int  WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               b_zero;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH-1:0]   div_quot;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quot_fix;

    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
    end

    // Multiply: acc_lo holds the multiplier and is shifted out as product bits shift in.
    always_comb begin
        mul_sum = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, opnd} : '0);
    end

    muldiv_divstep #(
        .WIDTH(WIDTH)
    ) u_divstep (
        .rem_in  (acc_hi),
        .quot_in (acc_lo),
        .divisor (opnd),
        .rem_out (div_rem),
        .quot_out(div_quot)
    );

    // A zero divisor leaves the raw dividend magnitude in the remainder, so sign fixup restores a.
    always_comb begin
        prod_mag = {acc_hi[WIDTH-1:0], acc_lo};
        prod_fix = neg_res ? -prod_mag : prod_mag;
        rem_mag  = acc_hi[WIDTH-1:0];
        rem_fix  = neg_rem ? -rem_mag : rem_mag;
        quot_fix = b_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= MD_IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                is_div   <= (op == MD_DIV) || (op == MD_DIVU);
                                neg_res  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem  <= signed_op && a[WIDTH-1];
                                b_zero   <= (b == '0);
                                acc_hi   <= '0;
                                if ((op == MD_DIV) || (op == MD_DIVU)) begin
                                    acc_lo <= a_mag;
                                    opnd   <= b_mag;
                                end else begin
                                    acc_lo <= b_mag;
                                    opnd   <= a_mag;
                                end
                                count    <= CNT_W'(WIDTH);
                                busy     <= 1'b1;
                                div_zero <= 1'b0;
                                state    <= MD_CALC;
                            end
                            MD_MTHI: begin
                                hi       <= a;
                                done     <= 1'b1;
                                div_zero <= 1'b0;
                            end
                            MD_MTLO: begin
                                lo       <= a;
                                done     <= 1'b1;
                                div_zero <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_CALC: begin
                    if (is_div) begin
                        acc_hi <= div_rem;
                        acc_lo <= div_quot;
                    end else begin
                        {acc_hi, acc_lo} <= {1'b0, mul_sum, acc_lo[WIDTH-1:1]};
                    end
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= MD_FIXUP;
                    end
                end
                MD_FIXUP: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    div_zero <= is_div && b_zero;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule
